pixel_step_sequencer: RTL and testbench

Control FSM that paces the pixel loader. It drives the 2 kHz `timer` block through its START/RESET inputs and consumes its DONE/RST_OK outputs. On a GO request it walks a pixel address from 0 to N_STEPS-1. For each address it clears the timer, waits one full dwell, then issues a one-cycle LOAD strobe to the downstream pixel writer.

---
 rtl/pixel_step_sequencer.sv | 141 ++++++++++++++
 tb/tb_pixel_step_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_step_sequencer.sv
// pixel_step_sequencer: paces the pixel loader against the 2 kHz timer.
// Walks ADDR from 0 to N_STEPS-1; per address it clears the timer, waits one
// full dwell, then strobes LOAD for one cycle. FINISHED pulses after the last LOAD.
//
// Handshake: there is no valid/ready pair here. GO is a level request sampled
// only in IDLE (never queued); ABORT is sampled in CLEAR/WAIT/LOAD and wins
// over every other transition. T_RST_OK and T_DONE are sampled as plain levels.
module pixel_step_sequencer #(
    parameter int N_STEPS = 16,
    parameter int ADDR_W  = 4
) (
    input  logic              clk_2K,
    input  logic              RESET_N,
    input  logic              GO,
    input  logic              ABORT,
    input  logic              T_DONE,
    input  logic              T_RST_OK,
    output logic              T_START,
    output logic              T_RESET,
    output logic [ADDR_W-1:0] ADDR,
    output logic              LOAD,
    output logic              BUSY,
    output logic              FINISHED,
    output logic [2:0]        STATE_DBG
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_WAIT   = 3'd2,
        S_LOAD   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_STEPS - 1);

    state_t            state;
    state_t            state_nxt;
    logic              dwell;
    logic              dwell_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              in_step;

    // A step is running in CLEAR, WAIT or LOAD; only there does ABORT act.
    assign in_step   = (state == S_CLEAR) || (state == S_WAIT) || (state == S_LOAD);
    assign STATE_DBG = state;

    // State, address and dwell flag registers.
    always_ff @(posedge clk_2K or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
            ADDR  <= '0;
            dwell <= 1'b0;
        end else begin
            state <= state_nxt;
            ADDR  <= addr_nxt;
            dwell <= dwell_nxt;
        end
    end

    // Next-state decode; ABORT overrides every transition out of a step state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (GO && !ABORT) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                if (ABORT)                  state_nxt = S_IDLE;
                else if (dwell && T_RST_OK) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (ABORT)       state_nxt = S_IDLE;
                else if (T_DONE) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (ABORT)                  state_nxt = S_IDLE;
                else if (ADDR == LAST_ADDR) state_nxt = S_FINISH;
                else                        state_nxt = S_CLEAR;
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Address advance and dwell flag; the flag forces a second CLEAR cycle so a
    // stale RST_OK left over from the previous reset cannot end CLEAR early.
    always_comb begin
        addr_nxt  = ADDR;
        dwell_nxt = dwell;
        if (state == S_IDLE && state_nxt == S_CLEAR) begin
            addr_nxt = '0;
        end else if (in_step && ABORT) begin
            addr_nxt = '0;
        end else if (state == S_LOAD && state_nxt == S_CLEAR) begin
            addr_nxt = ADDR + ADDR_W'(1);
        end
        if (state_nxt == S_CLEAR && state != S_CLEAR) begin
            dwell_nxt = 1'b0;
        end else if (state == S_CLEAR) begin
            dwell_nxt = 1'b1;
        end
    end

    // Moore output decode of the state register.
    always_comb begin
        T_RESET  = 1'b0;
        T_START  = 1'b0;
        LOAD     = 1'b0;
        BUSY     = 1'b0;
        FINISHED = 1'b0;
        case (state)
            S_IDLE: begin
                T_RESET = 1'b1;
            end
            S_CLEAR: begin
                T_RESET = 1'b1;
                BUSY    = 1'b1;
            end
            S_WAIT: begin
                T_START = 1'b1;
                BUSY    = 1'b1;
            end
            S_LOAD: begin
                LOAD = 1'b1;
                BUSY = 1'b1;
            end
            S_FINISH: begin
                FINISHED = 1'b1;
            end
            default: begin
                T_RESET = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pixel_step_sequencer.sv
// Bench for pixel_step_sequencer: two instances (N_STEPS=4 and N_STEPS=1) share
// GO/ABORT/stall stimulus; each has its own 3-bit timer model. A step-position
// model predicts every output each cycle; directed runs pin literal timings.
module tb_pixel_step_sequencer;

    localparam int TW    = 3;
    localparam int DWELL = 1 << TW;
    localparam int N0    = 4;
    localparam int N1    = 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic go    = 1'b0;
    logic abort = 1'b0;
    logic stall = 1'b0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic [1:0] t_done, t_rst_ok, t_start, t_reset, load, busy, fin;
    logic [3:0] addr0;
    logic [0:0] addr1;
    logic [2:0] st0, st1;

    pixel_step_sequencer #(.N_STEPS(N0), .ADDR_W(4)) dut0 (
        .clk_2K(clk), .RESET_N(rst_n), .GO(go), .ABORT(abort),
        .T_DONE(t_done[0]), .T_RST_OK(t_rst_ok[0]),
        .T_START(t_start[0]), .T_RESET(t_reset[0]), .ADDR(addr0),
        .LOAD(load[0]), .BUSY(busy[0]), .FINISHED(fin[0]), .STATE_DBG(st0)
    );

    pixel_step_sequencer #(.N_STEPS(N1), .ADDR_W(1)) dut1 (
        .clk_2K(clk), .RESET_N(rst_n), .GO(go), .ABORT(abort),
        .T_DONE(t_done[1]), .T_RST_OK(t_rst_ok[1]),
        .T_START(t_start[1]), .T_RESET(t_reset[1]), .ADDR(addr1),
        .LOAD(load[1]), .BUSY(busy[1]), .FINISHED(fin[1]), .STATE_DBG(st1)
    );

    // ---------------- timer models (2 kHz timer, WIDTH=3) ----------------
    int tcnt[2];
    bit tok[2];

    assign t_done[0]   = (tcnt[0] == DWELL - 1);
    assign t_done[1]   = (tcnt[1] == DWELL - 1);
    assign t_rst_ok[0] = tok[0] & ~stall;
    assign t_rst_ok[1] = tok[1] & ~stall;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (t_reset[i]) begin
                tcnt[i] <= 0;
                tok[i]  <= 1'b1;
            end else if (t_start[i]) begin
                tok[i] <= 1'b0;
                if (tcnt[i] < DWELL - 1) tcnt[i] <= tcnt[i] + 1;
            end
        end
    end

    // ---------------- behavioural model ----------------
    // A step is: clear phase (ends at the first edge, from its 2nd cycle on,
    // where RST_OK is seen), then DWELL wait cycles, then one load cycle.
    bit m_run[2];
    bit m_fin[2];
    int m_addr[2];
    int m_k[2];
    int m_clen[2] = '{-1, -1};

    function automatic int n_of(int i);
        return (i == 0) ? N0 : N1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i]  <= 1'b0;
                m_fin[i]  <= 1'b0;
                m_addr[i] <= 0;
                m_k[i]    <= 0;
                m_clen[i] <= -1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_fin[i]) begin
                    m_fin[i] <= 1'b0;
                end else if (!m_run[i]) begin
                    if (go && !abort) begin
                        m_run[i]  <= 1'b1;
                        m_addr[i] <= 0;
                        m_k[i]    <= 0;
                        m_clen[i] <= -1;
                    end
                end else if (abort) begin
                    m_run[i]  <= 1'b0;
                    m_addr[i] <= 0;
                end else if (m_clen[i] < 0) begin
                    if (m_k[i] >= 1 && t_rst_ok[i]) m_clen[i] <= m_k[i] + 1;
                    m_k[i] <= m_k[i] + 1;
                end else if (m_k[i] < m_clen[i] + DWELL) begin
                    m_k[i] <= m_k[i] + 1;
                end else if (m_addr[i] == n_of(i) - 1) begin
                    m_run[i] <= 1'b0;
                    m_fin[i] <= 1'b1;
                end else begin
                    m_addr[i] <= m_addr[i] + 1;
                    m_k[i]    <= 0;
                    m_clen[i] <= -1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_q[$];

    int ld_cyc0[$], ld_addr0[$], fin_cyc0[$];
    int ld_cyc1[$], fin_cyc1[$];
    int busy_cnt[2];
    int busy_start[2];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model, plus event logging.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [4:0] e_v, a_v;
            int         e_a, a_a;
            bit         e_clr, e_wait, e_load;
            e_clr  = m_run[i] && (m_clen[i] < 0);
            e_wait = m_run[i] && (m_clen[i] >= 0) && (m_k[i] < m_clen[i] + DWELL);
            e_load = m_run[i] && (m_clen[i] >= 0) && (m_k[i] >= m_clen[i] + DWELL);
            e_v = {(!m_run[i] && !m_fin[i]) || e_clr, e_wait, e_load, m_run[i], m_fin[i]};
            a_v = {t_reset[i], t_start[i], load[i], busy[i], fin[i]};
            e_a = m_addr[i];
            a_a = (i == 0) ? int'(addr0) : int'(addr1);
            n_tests++;
            if (e_v !== a_v || e_a != a_a) begin
                n_fail++;
                $display("FAIL cycle_compare cyc=%0d dut%0d: got rst/start/load/busy/fin=%b addr=%0d st=%0d, expected %b addr=%0d",
                         cyc, i, a_v, a_a, (i == 0) ? st0 : 3'(st1), e_v, e_a);
            end
            if (busy[i]) begin
                busy_cnt[i]++;
                if (busy_start[i] < 0) busy_start[i] = cyc;
            end
        end
        if (load[0]) begin
            ld_cyc0.push_back(cyc);
            ld_addr0.push_back(int'(addr0));
        end
        if (fin[0]) fin_cyc0.push_back(cyc);
        if (load[1]) ld_cyc1.push_back(cyc);
        if (fin[1])  fin_cyc1.push_back(cyc);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic clear_logs();
        ld_cyc0.delete(); ld_addr0.delete(); fin_cyc0.delete();
        ld_cyc1.delete(); fin_cyc1.delete();
        for (int i = 0; i < 2; i++) begin
            busy_cnt[i]   = 0;
            busy_start[i] = -1;
        end
    endtask

    task automatic wait_fin0(input int n, input string name);
        for (int t = 0; t < 200 && fin_cyc0.size() < n; t++) tick();
        check(name, int'(fin_cyc0.size() >= n), 1);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("rst_t_reset0", t_reset[0], 1);
        check("rst_t_start0", t_start[0], 0);
        check("rst_busy0",    busy[0],    0);
        check("rst_load0",    load[0],    0);
        check("rst_fin0",     fin[0],     0);
        check("rst_addr0",    addr0,      0);
        check("rst_t_reset1", t_reset[1], 1);
        check("rst_busy1",    busy[1],    0);
        rst_n = 1'b1;
        tick();
        tick();

        // Nominal run: 4 steps of 11 cycles each.
        clear_logs();
        pulse_go();
        wait_fin0(1, "nominal_timeout");
        tick();
        tick();
        check("nom_load_count", ld_cyc0.size(), 4);
        if (ld_cyc0.size() == 4) begin
            exp_q.delete();
            for (int j = 0; j < 4; j++) exp_q.push_back(4'(j));
            for (int j = 0; j < 4; j++) check($sformatf("nom_load_addr%0d", j), ld_addr0[j], int'(exp_q.pop_front()));
            for (int j = 0; j < 3; j++) check($sformatf("nom_gap%0d", j), ld_cyc0[j+1] - ld_cyc0[j], 11);
            check("nom_first_load_ofs", ld_cyc0[0] - busy_start[0], 10);
            if (fin_cyc0.size() == 1) check("nom_fin_after_load", fin_cyc0[0] - ld_cyc0[3], 1);
        end
        check("nom_fin_count",  fin_cyc0.size(), 1);
        check("nom_busy_cycles", busy_cnt[0], 44);
        check("nom_addr_holds",  addr0, 3);
        // Single-step instance ran alongside.
        check("one_load_count", ld_cyc1.size(), 1);
        check("one_fin_count",  fin_cyc1.size(), 1);
        if (ld_cyc1.size() == 1 && fin_cyc1.size() == 1)
            check("one_fin_after_load", fin_cyc1[0] - ld_cyc1[0], 1);
        check("one_busy_cycles", busy_cnt[1], 11);
        check("one_addr_holds",  addr1, 0);

        // Stalled timer: RST_OK low for the first 10 CLEAR cycles.
        clear_logs();
        go    = 1'b1;
        stall = 1'b1;
        tick();
        go = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("stall_clear%0d", k), {t_reset[0], busy[0], t_start[0]}, 3'b110);
            if (k < 9) tick();
        end
        stall = 1'b0;
        wait_fin0(1, "stall_timeout");
        tick();
        check("stall_busy_cycles", busy_cnt[0], 52);
        check("stall_busy_cycles1", busy_cnt[1], 19);
        if (ld_cyc0.size() == 4) begin
            check("stall_first_load_ofs", ld_cyc0[0] - busy_start[0], 18);
            check("stall_gap", ld_cyc0[1] - ld_cyc0[0], 11);
        end
        repeat (3) tick();

        // Abort during the WAIT of ADDR=1.
        clear_logs();
        pulse_go();
        for (int t = 0; t < 100 && !(addr0 == 4'd1 && t_start[0]); t++) tick();
        check("abort_wait_found", int'(addr0 == 4'd1 && t_start[0]), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_wait_busy",  busy[0],    0);
        check("abort_wait_treset", t_reset[0], 1);
        check("abort_wait_addr",  addr0,      0);
        repeat (20) tick();
        check("abort_wait_loads", ld_cyc0.size(), 1);
        check("abort_wait_fins",  fin_cyc0.size(), 0);

        // Abort exactly in the LOAD cycle of ADDR=3.
        clear_logs();
        pulse_go();
        for (int t = 0; t < 100 && !(addr0 == 4'd3 && load[0]); t++) tick();
        check("abort_load_found", int'(addr0 == 4'd3 && load[0]), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_load_busy", busy[0], 0);
        check("abort_load_fin",  fin[0],  0);
        check("abort_load_addr", addr0,   0);
        repeat (5) tick();
        check("abort_load_fins",  fin_cyc0.size(), 0);
        check("abort_load_loads", ld_cyc0.size(), 4);

        // GO held high for a whole run: no restart while busy, restart after FINISH.
        clear_logs();
        go = 1'b1;
        wait_fin0(1, "go_held_timeout");
        check("go_held_busy_cycles", busy_cnt[0], 44);
        tick();
        check("go_held_idle_busy",   busy[0],    0);
        check("go_held_idle_treset", t_reset[0], 1);
        tick();
        check("go_held_restart_busy", busy[0], 1);
        check("go_held_restart_addr", addr0,   0);
        go = 1'b0;
        wait_fin0(2, "go_held_second_timeout");
        repeat (3) tick();

        // Asynchronous reset mid-WAIT at ADDR=2.
        clear_logs();
        pulse_go();
        for (int t = 0; t < 100 && !(addr0 == 4'd2 && t_start[0]); t++) tick();
        check("areset_found", int'(addr0 == 4'd2 && t_start[0]), 1);
        rst_n = 1'b0;
        #1;
        check("areset_treset", t_reset[0], 1);
        check("areset_tstart", t_start[0], 0);
        check("areset_busy",   busy[0],    0);
        check("areset_addr",   addr0,      0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
        pulse_go();
        wait_fin0(1, "areset_rerun_timeout");
        check("areset_rerun_loads", ld_cyc0.size(), 4);
        if (ld_addr0.size() > 0) check("areset_rerun_addr0", ld_addr0[0], 0);
        repeat (3) tick();

        // Randomized traffic against the model.
        begin
            int stall_left;
            stall_left = 0;
            for (int n = 0; n < 3000; n++) begin
                go    = ($urandom_range(0, 7) == 0);
                abort = ($urandom_range(0, 63) == 0);
                if (stall_left > 0) begin
                    stall_left--;
                end else if ($urandom_range(0, 29) == 0) begin
                    stall_left = $urandom_range(1, 12);
                end
                stall = (stall_left > 0);
                tick();
            end
        end
        go    = 1'b0;
        abort = 1'b0;
        stall = 1'b0;
        repeat (60) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 1ms");
        $fatal(1, "watchdog");
    end

endmodule
